// File: rtl/signal_processing_pkg.sv
// Shared types and widths for the lock-in processing chain run controller.
package signal_processing_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned PARAM_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        DONE
    } sp_seq_state_t;

endpackage

// File: rtl/sp_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYCLES-1.
module sp_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == LAST);

endmodule

// File: rtl/signal_processing_sequencer.sv
// Run controller for the lock-in chain: latches config, pulses the chain reset,
// enables the chain, then collects phase/quadrature result pairs.
module signal_processing_sequencer
    import signal_processing_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2**24,
    parameter int unsigned CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       cfg_ptos_x_ciclo,
    input  logic [31:0]       cfg_frames_int,
    input  logic [31:0]       cfg_frames_prom,
    input  logic [31:0]       cfg_n_results,
    output logic [31:0]       par_ptos_x_ciclo,
    output logic [31:0]       par_frames_int,
    output logic [31:0]       par_frames_prom,
    output logic              chain_reset_n,
    output logic              chain_enable,
    input  logic              din_valid,
    input  logic              chain_ready,
    input  logic              chain_finished,
    input  logic [63:0]       out1,
    input  logic              out1_valid,
    input  logic [63:0]       out2,
    input  logic              out2_valid,
    output logic [63:0]       result_x,
    output logic [63:0]       result_y,
    output logic              result_valid,
    output logic [CNT_W-1:0]  sample_count,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              sync_err
);

    localparam int unsigned LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);

    sp_seq_state_t        state;
    logic [LOAD_W-1:0]    load_count;
    logic [PARAM_W-1:0]   result_count;
    logic [PARAM_W-1:0]   n_target;
    logic                 start_accept;
    logic                 pair;
    logic                 wd_terminal;

    assign start_accept = start && !abort && (state == IDLE || state == DONE);
    assign pair         = out1_valid && out2_valid;

    sp_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .terminal(wd_terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            load_count       <= '0;
            result_count     <= '0;
            n_target         <= '0;
            par_ptos_x_ciclo <= '0;
            par_frames_int   <= '0;
            par_frames_prom  <= '0;
            chain_reset_n    <= 1'b0;
            chain_enable     <= 1'b0;
            result_x         <= '0;
            result_y         <= '0;
            result_valid     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            timeout_err      <= 1'b0;
            sync_err         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            // Abort outranks everything, including a pair arriving the same cycle.
            if (abort && state != IDLE) begin
                state         <= IDLE;
                chain_reset_n <= 1'b0;
                chain_enable  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_accept) begin
                            state            <= LOAD;
                            par_ptos_x_ciclo <= cfg_ptos_x_ciclo;
                            par_frames_int   <= cfg_frames_int;
                            par_frames_prom  <= cfg_frames_prom;
                            n_target         <= (cfg_n_results == '0) ? PARAM_W'(1) : cfg_n_results;
                            result_count     <= '0;
                            load_count       <= '0;
                            timeout_err      <= 1'b0;
                            sync_err         <= 1'b0;
                            chain_reset_n    <= 1'b0;
                            chain_enable     <= 1'b0;
                            busy             <= 1'b1;
                            done             <= 1'b0;
                        end
                    end
                    LOAD: begin
                        load_count <= load_count + 1'b1;
                        if (load_count == LOAD_LAST) begin
                            state         <= RUN;
                            chain_reset_n <= 1'b1;
                            chain_enable  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (chain_ready) begin
                            state <= CAPTURE;
                        end else if (wd_terminal) begin
                            state        <= DONE;
                            timeout_err  <= 1'b1;
                            chain_enable <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (pair) begin
                            result_x     <= out1;
                            result_y     <= out2;
                            result_valid <= 1'b1;
                            result_count <= result_count + 1'b1;
                        end else if (out1_valid != out2_valid) begin
                            sync_err <= 1'b1;
                        end
                        if (chain_finished || (pair && (result_count + 1'b1 == n_target))) begin
                            state        <= DONE;
                            chain_enable <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            sample_count <= '0;
        end else if (chain_enable && din_valid && sample_count != '1) begin
            sample_count <= sample_count + 1'b1;
        end
    end

endmodule
